// File: rtl/itch_msg_parser_pkg.sv
// Shared ITCH 5.0 parser definitions: type codes, nominal lengths, body field
// offsets, parser states and the decoded message record.
package itch_pkg;

  localparam logic [7:0] TYPE_A = 8'h41;
  localparam logic [7:0] TYPE_E = 8'h45;
  localparam logic [7:0] TYPE_X = 8'h58;
  localparam logic [7:0] TYPE_D = 8'h44;
  localparam logic [7:0] TYPE_P = 8'h50;
  localparam logic [7:0] CHAR_B = 8'h42;

  localparam logic [15:0] LEN_A = 16'd36;
  localparam logic [15:0] LEN_E = 16'd31;
  localparam logic [15:0] LEN_X = 16'd23;
  localparam logic [15:0] LEN_D = 16'd19;
  localparam logic [15:0] LEN_P = 16'd44;

  localparam logic [15:0] OFF_OID_LO   = 16'd10;
  localparam logic [15:0] OFF_OID_HI   = 16'd17;
  localparam logic [15:0] OFF_SIDE     = 16'd18;
  localparam logic [15:0] OFF_VOLAP_LO = 16'd19;
  localparam logic [15:0] OFF_VOLAP_HI = 16'd22;
  localparam logic [15:0] OFF_VOLEX_LO = 16'd18;
  localparam logic [15:0] OFF_VOLEX_HI = 16'd21;
  localparam logic [15:0] OFF_PRICE_LO = 16'd31;
  localparam logic [15:0] OFF_PRICE_HI = 16'd34;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_TYPE   = 3'd2,
    ST_BODY   = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [63:0] order_id;
    logic [31:0] volume;
    logic [31:0] price;
    logic        side;
  } itch_msg_t;

  localparam int MSG_W = $bits(itch_msg_t);

  // Nominal length of an enabled type; zero marks a disabled or unknown type.
  function automatic logic [15:0] nominal_len(input logic [7:0] code, input logic [4:0] en);
    case (code)
      TYPE_A:  nominal_len = en[0] ? LEN_A : 16'd0;
      TYPE_E:  nominal_len = en[1] ? LEN_E : 16'd0;
      TYPE_X:  nominal_len = en[2] ? LEN_X : 16'd0;
      TYPE_D:  nominal_len = en[3] ? LEN_D : 16'd0;
      TYPE_P:  nominal_len = en[4] ? LEN_P : 16'd0;
      default: nominal_len = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_msg_parser_out_slot.sv
// One-entry valid/ready holding register for a decoded ITCH message.
module itch_out_slot
  import itch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [MSG_W-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [MSG_W-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [MSG_W-1:0] data_q, data_d;

  // A load wins over a consume so a final byte and a handshake in one cycle stream back-to-back.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/itch_msg_parser.sv
// Byte-serial ITCH 5.0 parser for A/E/X/D/P messages with length checking,
// statistics counters and valid/ready flow control on both sides.
module itch_msg_parser
  import itch_pkg::*;
#(
  parameter logic [4:0] TYPE_EN = 5'b11111,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       msg_type,
  output logic [63:0]      order_id,
  output logic [31:0]      volume,
  output logic [31:0]      price,
  output logic             side,
  output logic [CNT_W-1:0] msg_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      left_q, left_d;
  logic [15:0]      off_q, off_d;
  itch_msg_t        acc_q, acc_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d, skip_cnt_q, skip_cnt_d, err_cnt_q, err_cnt_d;
  logic             last_s, free_s, in_ready_s, accept_s, load_s, is_ap_s, is_ex_s;
  logic [15:0]      nom_s;
  logic [MSG_W-1:0] slot_data_s;
  itch_msg_t        out_msg_s;

  // Next-state, field accumulation and counter logic.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    left_d     = left_q;
    off_d      = off_q;
    acc_d      = acc_q;
    msg_cnt_d  = msg_cnt_q;
    skip_cnt_d = skip_cnt_q;
    err_cnt_d  = err_cnt_q;
    load_s     = 1'b0;
    last_s     = (left_q == 16'd1);
    in_ready_s = !((state_q == ST_BODY) && last_s && !free_s);
    accept_s   = in_valid && in_ready_s;
    nom_s      = nominal_len(in_byte, TYPE_EN);
    is_ap_s    = (acc_q.msg_type == TYPE_A) || (acc_q.msg_type == TYPE_P);
    is_ex_s    = (acc_q.msg_type == TYPE_E) || (acc_q.msg_type == TYPE_X);
    if (accept_s) begin
      case (state_q)
        ST_HDR_HI: begin
          len_hi_d = in_byte;
          state_d  = ST_HDR_LO;
        end
        ST_HDR_LO: begin
          left_d = {len_hi_q, in_byte};
          if ({len_hi_q, in_byte} == 16'd0) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
            state_d   = ST_HDR_HI;
          end else begin
            state_d = ST_TYPE;
          end
        end
        ST_TYPE: begin
          // left_q still holds L here; it becomes the body byte count.
          acc_d          = '0;
          acc_d.msg_type = in_byte;
          off_d          = 16'd0;
          left_d         = left_q - 16'd1;
          if (nom_s == 16'd0) begin
            skip_cnt_d = skip_cnt_q + CNT_ONE;
            state_d    = ST_SKIP;
          end else if (nom_s == left_q) begin
            state_d = ST_BODY;
          end else begin
            err_cnt_d = err_cnt_q + CNT_ONE;
            state_d   = ST_SKIP;
          end
          if (left_q == 16'd1) begin
            state_d = ST_HDR_HI;
          end else begin
            state_d = state_d;
          end
        end
        ST_BODY, ST_SKIP: begin
          off_d  = off_q + 16'd1;
          left_d = left_q - 16'd1;
          if (state_q == ST_BODY) begin
            if (off_q >= OFF_OID_LO && off_q <= OFF_OID_HI) begin
              acc_d.order_id = {acc_q.order_id[55:0], in_byte};
            end else begin
              acc_d.order_id = acc_q.order_id;
            end
            if (is_ap_s) begin
              if (off_q == OFF_SIDE) begin
                acc_d.side = (in_byte == CHAR_B);
              end else if (off_q >= OFF_VOLAP_LO && off_q <= OFF_VOLAP_HI) begin
                acc_d.volume = {acc_q.volume[23:0], in_byte};
              end else if (off_q >= OFF_PRICE_LO && off_q <= OFF_PRICE_HI) begin
                acc_d.price = {acc_q.price[23:0], in_byte};
              end else begin
                acc_d.side = acc_q.side;
              end
            end else if (is_ex_s && off_q >= OFF_VOLEX_LO && off_q <= OFF_VOLEX_HI) begin
              acc_d.volume = {acc_q.volume[23:0], in_byte};
            end else begin
              acc_d.volume = acc_q.volume;
            end
          end else begin
            acc_d = acc_q;
          end
          if (last_s) begin
            state_d = ST_HDR_HI;
            if (state_q == ST_BODY) begin
              load_s    = 1'b1;
              msg_cnt_d = msg_cnt_q + CNT_ONE;
            end else begin
              load_s = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_HDR_HI;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Parser state, accumulators and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HDR_HI;
      len_hi_q   <= 8'd0;
      left_q     <= 16'd0;
      off_q      <= 16'd0;
      acc_q      <= '0;
      msg_cnt_q  <= '0;
      skip_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      left_q     <= left_d;
      off_q      <= off_d;
      acc_q      <= acc_d;
      msg_cnt_q  <= msg_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  itch_out_slot u_slot (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .load_i  (load_s),
    .data_i  (acc_d),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (slot_data_s),
    .free_o  (free_s)
  );

  assign out_msg_s = slot_data_s;
  assign msg_type  = out_msg_s.msg_type;
  assign order_id  = out_msg_s.order_id;
  assign volume    = out_msg_s.volume;
  assign price     = out_msg_s.price;
  assign side      = out_msg_s.side;
  assign in_ready  = in_ready_s;
  assign msg_cnt   = msg_cnt_q;
  assign skip_cnt  = skip_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Self-checking bench for itch_msg_parser: table of messages with a scoreboard
// queue, plus backpressure, type-mask and mid-message reset sequences.
module tb_itch_msg_parser;
  import itch_pkg::*;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] len;
    logic [63:0] oid;
    logic [7:0]  sideb;
    logic [31:0] shares;
    logic [31:0] price;
    logic [1:0]  cls;       // 0 emitted, 1 skipped, 2 malformed
    logic [31:0] exp_vol;
    logic [31:0] exp_price;
    logic        exp_side;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, sel;
  logic [7:0] in_byte;
  logic rdy1, ov1, side1, rdy2, ov2, side2;
  logic [7:0] mt1, mt2;
  logic [63:0] oid1, oid2;
  logic [31:0] vol1, pr1, mc1, sc1, ec1, vol2, pr2, mc2, sc2, ec2;

  itch_msg_parser dut1 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid & ~sel),
    .in_ready(rdy1), .out_valid(ov1), .out_ready(out_ready), .msg_type(mt1),
    .order_id(oid1), .volume(vol1), .price(pr1), .side(side1),
    .msg_cnt(mc1), .skip_cnt(sc1), .err_cnt(ec1));

  itch_msg_parser #(.TYPE_EN(5'b10000)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid & sel),
    .in_ready(rdy2), .out_valid(ov2), .out_ready(out_ready), .msg_type(mt2),
    .order_id(oid2), .volume(vol2), .price(pr2), .side(side2),
    .msg_cnt(mc2), .skip_cnt(sc2), .err_cnt(ec2));

  logic      rdy_m, ov_m;
  itch_msg_t msg_m;
  assign rdy_m = sel ? rdy2 : rdy1;
  assign ov_m  = sel ? ov2 : ov1;
  assign msg_m = sel ? {mt2, oid2, vol2, pr2, side2} : {mt1, oid1, vol1, pr1, side1};

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  itch_msg_t exp_q[$];
  logic [7:0] byte_q[$];
  vec_t vec[10];

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expected message.
  always @(negedge clk) begin
    if (rst_n && ov_m && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 200'(msg_m), 200'd0);
      end else begin
        check("out_msg", 200'(msg_m), 200'(exp_q.pop_front()));
      end
    end
  end

  task automatic put(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    @(negedge clk);
    while (!rdy_m && n < 300) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("accept_timeout", 200'd0, 200'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic build(input vec_t v);
    logic [7:0] b;
    int k;
    byte_q = {};
    byte_q.push_back(v.len[15:8]);
    byte_q.push_back(v.len[7:0]);
    if (v.len != 16'd0) begin
      byte_q.push_back(v.code);
      for (int off = 0; off < int'(v.len) - 1; off++) begin
        b = 8'hA0 ^ 8'(off);
        if (off >= 10 && off <= 17) begin
          k = 17 - off; b = v.oid[8*k +: 8];
        end else if ((v.code == TYPE_A || v.code == TYPE_P) && off == 18) begin
          b = v.sideb;
        end else if ((v.code == TYPE_A || v.code == TYPE_P) && off >= 19 && off <= 22) begin
          k = 22 - off; b = v.shares[8*k +: 8];
        end else if ((v.code == TYPE_A || v.code == TYPE_P) && off >= 31 && off <= 34) begin
          k = 34 - off; b = v.price[8*k +: 8];
        end else if ((v.code == TYPE_E || v.code == TYPE_X) && off >= 18 && off <= 21) begin
          k = 21 - off; b = v.shares[8*k +: 8];
        end
        byte_q.push_back(b);
      end
    end
  endtask

  task automatic send(input vec_t v, input bit push, input int maxgap);
    itch_msg_t e;
    build(v);
    if (push && v.cls == 2'd0) begin
      e = '{msg_type: v.code, order_id: v.oid, volume: v.exp_vol, price: v.exp_price, side: v.exp_side};
      exp_q.push_back(e);
    end
    foreach (byte_q[i]) put(byte_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic check_counters(input string name, input logic [31:0] m, s, e,
                                input int em, input int es, input int ee);
    check({name, "_msg_cnt"}, 200'(m), 200'(em));
    check({name, "_skip_cnt"}, 200'(s), 200'(es));
    check({name, "_err_cnt"}, 200'(e), 200'(ee));
  endtask

  initial begin
    int exp_msg, exp_skip, exp_err, n;
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b1; sel = 1'b0;

    vec[0] = '{TYPE_A, 16'd36, 64'h1234, 8'h42, 32'd100, 32'd1500000, 2'd0, 32'd100, 32'd1500000, 1'b1};
    vec[1] = '{TYPE_E, 16'd31, 64'hABCD, 8'h42, 32'd50, 32'h5555, 2'd0, 32'd50, 32'd0, 1'b0};
    vec[2] = '{TYPE_D, 16'd19, 64'h1122334455667788, 8'h42, 32'd999, 32'd7, 2'd0, 32'd0, 32'd0, 1'b0};
    vec[3] = '{8'h53, 16'd12, 64'h0, 8'h42, 32'd1, 32'd1, 2'd1, 32'd0, 32'd0, 1'b0};
    vec[4] = '{TYPE_X, 16'd20, 64'h77, 8'h42, 32'd3, 32'd0, 2'd2, 32'd0, 32'd0, 1'b0};
    vec[5] = '{TYPE_A, 16'd0, 64'h0, 8'h42, 32'd0, 32'd0, 2'd2, 32'd0, 32'd0, 1'b0};
    vec[6] = '{TYPE_X, 16'd23, 64'hDEADBEEF00000001, 8'h42, 32'd7, 32'd0, 2'd0, 32'd7, 32'd0, 1'b0};
    vec[7] = '{TYPE_A, 16'd36, 64'hFFFFFFFFFFFFFFFF, 8'h53, 32'hFFFFFFFF, 32'h80000001, 2'd0, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vec[8] = '{TYPE_P, 16'd44, 64'd42, 8'h42, 32'd300, 32'd99, 2'd0, 32'd300, 32'd99, 1'b1};
    vec[9] = '{TYPE_E, 16'd1, 64'h0, 8'h42, 32'd0, 32'd0, 2'd2, 32'd0, 32'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 200'(rdy1), 200'd1);
    check("rst_out_valid", 200'(ov1), 200'd0);
    check("rst_fields", 200'({mt1, oid1, vol1, pr1, side1}), 200'd0);
    check_counters("rst", mc1, sc1, ec1, 0, 0, 0);
    @(posedge clk); #1;

    // Table of messages, out_ready held high, no input gaps.
    exp_msg = 0; exp_skip = 0; exp_err = 0; stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(vec[i], 1'b1, 0);
      if (i == 0) check("latency_out_valid", 200'(ov1), 200'd1);
      case (vec[i].cls)
        2'd0: exp_msg++;
        2'd1: exp_skip++;
        default: exp_err++;
      endcase
    end
    repeat (2) @(posedge clk); #1;
    check("no_stall", 200'(stall_cnt), 200'd0);
    check_counters("table", mc1, sc1, ec1, exp_msg, exp_skip, exp_err);

    // Backpressure: two P messages, the second stalls on its last byte.
    out_ready = 1'b0;
    send(vec[8], 1'b1, 0);
    v = vec[8]; v.oid = 64'h0102030405060708; v.sideb = 8'h53; v.exp_side = 1'b0; v.price = 32'd12345; v.exp_price = 32'd12345;
    fork
      send(v, 1'b1, 0);
      begin
        n = 0;
        while (rdy1 && n < 300) begin @(negedge clk); n++; end
        check("stall_seen", 200'(rdy1), 200'd0);
        repeat (3) @(negedge clk);
        check("held_valid", 200'(ov1), 200'd1);
        check("held_oid", 200'(oid1), 200'(vec[8].oid));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("back_to_back_valid", 200'(ov1), 200'd1);
    check("back_to_back_oid", 200'(oid1), 200'(v.oid));
    exp_msg += 2;
    repeat (2) @(posedge clk); #1;
    check("bp_msg_cnt", 200'(mc1), 200'(exp_msg));

    // Type mask on dut2: only P is parsed, with and without input gaps.
    sel = 1'b1;
    v = vec[0]; v.cls = 2'd1;
    send(v, 1'b1, 0);
    send(vec[8], 1'b1, 0);
    send(vec[8], 1'b1, 3);
    repeat (2) @(posedge clk); #1;
    check_counters("mask", mc2, sc2, ec2, 2, 1, 0);
    sel = 1'b0;

    // Reset mid-message with a held output.
    out_ready = 1'b0;
    send(vec[0], 1'b0, 0);
    check("pre_rst_valid", 200'(ov1), 200'd1);
    build(vec[8]);
    for (int i = 0; i < 18; i++) put(byte_q[i], 0);
    in_byte = byte_q[18]; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 200'(ov1), 200'd0);
    check("mid_rst_fields", 200'({mt1, oid1, vol1, pr1, side1}), 200'd0);
    check_counters("mid_rst", mc1, sc1, ec1, 0, 0, 0);
    check("mid_rst_dut2_msg", 200'(mc2), 200'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vec[0], 1'b1, 0);
    repeat (2) @(posedge clk); #1;
    check_counters("post_rst", mc1, sc1, ec1, 1, 0, 0);
    check("queue_empty", 200'(exp_q.size()), 200'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_msg_parser.md
# itch_msg_parser

Byte-serial NASDAQ ITCH 5.0 message parser. It succeeds the single-type trade parser by decoding five message types (A, E, X, D, P), each individually enabled by a mask, and by adding true backpressure on both sides. It also length-checks messages and keeps statistics counters. It sits between the framed byte stream from the session layer and the order-book update logic.

## Interface
- TYPE_EN, default 5'b11111: enable mask; bit0=A(0x41), bit1=E(0x45), bit2=X(0x58), bit3=D(0x44), bit4=P(0x50). A disabled type is skipped as unparsed.
- CNT_W, default 32: width of the statistics counters.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_byte  in  8  stream byte; order is len_hi, len_lo, type, body.
- in_valid  in  1  byte present.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  decoded message held.
- out_ready  in  1  consumer takes the message when out_valid && out_ready.
- msg_type  out  8  type byte.
- order_id  out  64  order reference number.
- volume  out  32  shares (A, P), executed shares (E), cancelled shares (X); 0 for D.
- price  out  32  price (A, P); 0 otherwise.
- side  out  1  1 when the buy/sell byte is 'B' (A, P); 0 otherwise.
- msg_cnt  out  CNT_W  messages emitted.
- skip_cnt  out  CNT_W  well-formed messages that are unparsed or disabled.
- err_cnt  out  CNT_W  malformed messages.

## Operation
- States: HDR_HI, HDR_LO, TYPE, BODY, SKIP. After reset the state is HDR_HI.
- HDR_HI/HDR_LO capture length L, big-endian. L counts the type byte plus the body.
- Length 0: err_cnt+1 and the state returns to HDR_HI. No type byte is consumed.
- TYPE:
  - Clear the accumulators. Set body_left = L-1.
  - Enabled type with L == nominal length (A 36, E 31, X 23, D 19, P 44) → BODY.
  - Enabled type with any other L → SKIP, err_cnt+1.
  - Disabled or unknown type → SKIP, skip_cnt+1.
  - If body_left == 0, go directly to HDR_HI.
- Body offsets are counted from 0, the first byte after type. Fields shift in MSB-first:
  - All parsed types: order_id = bytes 10..17.
  - A/P: side = byte 18; volume = bytes 19..22; price = bytes 31..34.
  - E/X: volume = bytes 18..21.
- Last body byte (offset L-2):
  - In BODY: the output register loads the fully assembled fields, out_valid=1, msg_cnt+1.
  - In both BODY and SKIP: state → HDR_HI.
- Counters are free-running modulo 2^CNT_W and wrap silently.

## Timing
- Reset values: out_valid=0; msg_type, order_id, volume, price, side all 0; all counters 0; in_ready=1.
- in_ready is combinational: it is 0 only when the state is BODY, the current byte is the last body byte, and out_valid && !out_ready. It is 1 in every other case.
- The parser stalls only on that last byte. Skipped messages never stall.
- Latency: out_valid rises the cycle after the last body byte is accepted.
- If a final byte is accepted in the same cycle the held message is consumed, the output reloads and out_valid stays 1, giving back-to-back output.
- out_valid clears the cycle after the handshake if no new load occurs.
- Output fields stay stable while out_valid && !out_ready.
- in_valid low in any state holds the state and the byte counter.
- A header byte may be accepted the cycle after the last body byte, so the parser sustains 1 byte/clk.
- Reset asserted mid-message aborts it and clears the output. No counter increments for the aborted message.

## Structure
- Package itch_pkg holds:
  - type code constants, nominal lengths, and field offsets;
  - the state enum;
  - a packed itch_msg_t struct {msg_type, order_id, volume, price, side}.
- Sub-module itch_out_slot: a one-entry valid/ready holding register for itch_msg_t, exposing a load strobe and a "free" signal (free = !out_valid || out_ready). The parser FSM and field accumulators stay in itch_msg_parser.

## Test plan
- A message, L=36, order_id 0x0000000000001234, side 'B', shares 100, price 1500000, out_ready=1 → one out_valid pulse with msg_type 0x41, side=1, volume=100, price=1500000; msg_cnt=1.
- E message with executed shares 50, followed back-to-back by D with L=19 → two outputs: E volume=50; D volume=0 and price=0. The input never stalls.
- P message held with out_ready=0, then a second P arrives → in_ready drops on the second message's last byte. When out_ready=1 the first output is consumed and the second loads in the same cycle.
- Type 'S' (0x53) with L=12, then type 'X' with L=20 (bad length), then L=0 → no outputs; skip_cnt=1, err_cnt=2; a following valid X decodes correctly.
- TYPE_EN=5'b10000: an A message is skipped (skip_cnt=1) and a P message is parsed. Random in_valid gaps inside a P give an identical result.
- rst_n low on body byte 15 of a P message → all outputs and counters return to 0. The next clean A message decodes correctly.
